// File: rtl/mux_1bit.sv
// -----------------------------------------------------------------------------
// mux_1bit
//   Two-input 1-bit selector with a combinational result, an enable-gated
//   registered copy, and an optional saturating select-transition counter.
//
//   Optional feature macro: MUX_1BIT_SWITCH_COUNT_EN
//     defined   : transition detector, switch_count and switch_evt are live
//     undefined : switch_count tied to zero, switch_evt tied to 0
//
//   Ports:
//     clk          in   system clock, rising edge
//     rst_n        in   asynchronous active-low reset
//     en           in   update enable for S, sel_q and the counter
//     A            in   data input chosen when Select_bit = 0
//     B            in   data input chosen when Select_bit = 1
//     Select_bit   in   select control
//     S_comb       out  combinational mux result
//     S            out  registered mux result
//     sel_q        out  registered copy of Select_bit
//     switch_count out  saturating count of select changes (CNT_W bits)
//     switch_evt   out  one-cycle pulse for each counted select change
// -----------------------------------------------------------------------------
module mux_1bit #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             A,
   input  logic             B,
   input  logic             Select_bit,
   output logic             S_comb,
   output logic             S,
   output logic             sel_q,
   output logic [CNT_W-1:0] switch_count,
   output logic             switch_evt
);

   logic w_mux;
   logic r_s;
   logic r_sel_q;

   always_comb begin
      w_mux = Select_bit ? B : A;
   end

   assign S_comb = w_mux;
   assign S      = r_s;
   assign sel_q  = r_sel_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s     <= 1'b0;
         r_sel_q <= 1'b0;
      end else if (en) begin
         r_s     <= w_mux;
         r_sel_q <= Select_bit;
      end
   end

`ifdef MUX_1BIT_SWITCH_COUNT_EN
   logic             w_change;
   logic             w_sat;
   logic [CNT_W-1:0] r_count;
   logic             r_evt;

   // A change is only "counted" (and so only pulses) while headroom remains.
   assign w_change = en & (Select_bit ^ r_sel_q);
   assign w_sat    = &r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_evt   <= 1'b0;
      end else begin
         r_evt <= w_change & ~w_sat;
         if (w_change && !w_sat) begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   assign switch_count = r_count;
   assign switch_evt   = r_evt;
`else
   assign switch_count = '0;
   assign switch_evt   = 1'b0;
`endif

endmodule

// File: tb/tb_mux_1bit.sv
// -----------------------------------------------------------------------------
// tb_mux_1bit
//   Randomized and directed bench for mux_1bit. Two instances are driven in
//   parallel: the default counter width and a 2-bit counter for saturation.
//   A reference model predicts registered outputs each edge and pushes them
//   into a queue; a monitor pops and compares just after each edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mux_1bit;

`ifdef MUX_1BIT_SWITCH_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       A = 1'b0;
   logic       B = 1'b0;
   logic       Select_bit = 1'b0;

   logic       S_comb, S, sel_q, switch_evt;
   logic [7:0] switch_count;
   logic       S_comb2, S2, sel_q2, switch_evt2;
   logic [1:0] switch_count2;

   int checks = 0;
   int failures = 0;

   mux_1bit #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .A(A), .B(B), .Select_bit(Select_bit),
      .S_comb(S_comb), .S(S), .sel_q(sel_q),
      .switch_count(switch_count), .switch_evt(switch_evt)
   );

   mux_1bit #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en), .A(A), .B(B), .Select_bit(Select_bit),
      .S_comb(S_comb2), .S(S2), .sel_q(sel_q2),
      .switch_count(switch_count2), .switch_evt(switch_evt2)
   );

   always #5 clk = ~clk;

   typedef struct {
      int s;
      int sq;
      int c8;
      int e8;
      int c2;
      int e2;
   } exp_t;

   exp_t q[$];

   // Reference model state
   int m_s = 0, m_sq = 0, m_c8 = 0, m_e8 = 0, m_c2 = 0, m_e2 = 0;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Advance the model by one rising edge, using the inputs present at it.
   task automatic model_edge();
      exp_t e;
      int chg;
      if (!rst_n) begin
         m_s = 0; m_sq = 0; m_c8 = 0; m_e8 = 0; m_c2 = 0; m_e2 = 0;
      end else if (en) begin
         chg  = (int'(Select_bit) != m_sq) ? 1 : 0;
         m_e8 = (CNT_ON && chg == 1 && m_c8 < 255) ? 1 : 0;
         m_e2 = (CNT_ON && chg == 1 && m_c2 < 3) ? 1 : 0;
         m_c8 = m_c8 + m_e8;
         m_c2 = m_c2 + m_e2;
         m_s  = Select_bit ? int'(B) : int'(A);
         m_sq = int'(Select_bit);
      end else begin
         m_e8 = 0;
         m_e2 = 0;
      end
      e.s = m_s; e.sq = m_sq; e.c8 = m_c8; e.e8 = m_e8; e.c2 = m_c2; e.e2 = m_e2;
      q.push_back(e);
   endtask

   // Monitor: registered outputs settle shortly after each edge.
   always @(posedge clk) begin
      #1;
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("S",            int'(S),             e.s);
         chk("sel_q",        int'(sel_q),         e.sq);
         chk("switch_count", int'(switch_count),  e.c8);
         chk("switch_evt",   int'(switch_evt),    e.e8);
         chk("S_w2",         int'(S2),            e.s);
         chk("switch_count_w2", int'(switch_count2), e.c2);
         chk("switch_evt_w2",   int'(switch_evt2),   e.e2);
      end
   end

   // Drive one cycle of inputs after the falling edge, check the
   // combinational path, then let the model account for the next edge.
   task automatic drive(input logic a, input logic b, input logic s, input logic e);
      @(negedge clk);
      A = a; B = b; Select_bit = s; en = e;
      #1;
      chk("S_comb", int'(S_comb), s ? int'(b) : int'(a));
      @(posedge clk);
      model_edge();
   endtask

   task automatic mid_reset_check();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_S",     int'(S),            0);
      chk("rst_sel_q", int'(sel_q),        0);
      chk("rst_count", int'(switch_count), 0);
      chk("rst_evt",   int'(switch_evt),   0);
      chk("rst_S_comb", int'(S_comb), Select_bit ? int'(B) : int'(A));
   endtask

   task automatic release_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] tt;
      logic [2:0] v;
      tt = 8'b1010_1100;

      // Reset values before any edge
      #1;
      chk("init_S",     int'(S),            0);
      chk("init_sel_q", int'(sel_q),        0);
      chk("init_count", int'(switch_count), 0);
      chk("init_evt",   int'(switch_evt),   0);
      drive(1'b1, 1'b0, 1'b0, 1'b1);   // S_comb tracks while in reset
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      release_reset();

      // Truth table, {Select_bit, A, B} = 0..7
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         @(negedge clk);
         Select_bit = v[2]; A = v[1]; B = v[0]; en = 1'b1;
         #1;
         chk("truth_table", int'(S_comb), int'(tt[i]));
         @(posedge clk);
         model_edge();
      end

      // Enable gating
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b1);

      // Counter: five toggles from a fresh reset, then hold
      mid_reset_check();
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      release_reset();
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("count_after_5", int'(switch_count), CNT_ON ? 5 : 0);

      // Async reset with S = 1 and count = 3
      mid_reset_check();
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      release_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("pre_rst_S",     int'(S),            1);
      chk("pre_rst_count", int'(switch_count), CNT_ON ? 3 : 0);
      mid_reset_check();
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      release_reset();

      // Saturation on the 2-bit instance
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
      @(negedge clk);
      chk("sat_count_w2", int'(switch_count2), CNT_ON ? 3 : 0);
      chk("sat_count_w8", int'(switch_count),  CNT_ON ? 6 : 0);

      // Random traffic with occasional asynchronous resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            mid_reset_check();
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            release_reset();
         end else begin
            drive(1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
         end
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
